counters_run_ctrl: RTL and testbench
====================================

COUNTERS_RUN_CTRL -- requirements
Module: counters_run_ctrl

Interface
REQ-001 SHALL have parameter DONE_W, default 4: width of the done bus from the counters datapath.
REQ-002 SHALL have parameter CNT_W, default 16: width of the cycle limit and the cycle count.
REQ-003 SHALL have port clk, input, 1: single clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port start_valid, input, 1: run request.
REQ-006 SHALL have port start_ready, output, 1: run request can be accepted.
REQ-007 SHALL have port start_mask, input, DONE_W: done bits required for completion; sampled on accept.
REQ-008 SHALL have port start_limit, input, CNT_W: timeout cycle limit (0 = unlimited); sampled on accept.
REQ-009 SHALL have port abort, input, 1: terminate the active run.
REQ-010 SHALL have port enable, output, 1: drives the enable input of the counters datapath.
REQ-011 SHALL have port done, input, DONE_W: done bus from the counters datapath.
REQ-012 SHALL have port result_valid, output, 1: a result is presented.
REQ-013 SHALL have port result_ready, input, 1: the result is consumed.
REQ-014 SHALL have port result_status, output, 2: 00 OK, 01 TIMEOUT, 10 ABORT.
REQ-015 SHALL have port result_cycles, output, CNT_W: number of cycles enable was high during the run.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN, REPORT.
REQ-017 start_ready SHALL equal 1 only in IDLE; the request is accepted when start_valid && start_ready.
REQ-018 start_valid outside IDLE SHALL be ignored and not queued.
REQ-019 On accept with start_mask != 0: go to RUN and clear the cycle count.
REQ-020 On accept with start_mask == 0: go directly to REPORT with status OK and cycles 0; enable is never asserted.
REQ-021 enable SHALL be registered and equal 1 exactly in the cycles the FSM is in RUN; first assertion is 1 cycle after accept.
REQ-022 In RUN, the cycle count SHALL increment every cycle and saturate at all-ones.
REQ-023 In RUN, when (done & mask) == mask, go to REPORT with status OK; enable is low in the following cycle.
REQ-024 In RUN, when abort = 1 (and the REQ-023 condition is false), go to REPORT with status ABORT.
REQ-025 Priority when events coincide in the same cycle: OK > TIMEOUT > ABORT.
REQ-026 In REPORT: result_valid = 1, and status and cycles are held stable until result_ready = 1; then go to IDLE.
REQ-027 result_valid SHALL drop the cycle after the handshake; back-to-back start on the next IDLE cycle is allowed.
REQ-028 abort SHALL have no effect in IDLE or REPORT.

Reset
REQ-029 While rst = 1, asynchronously: state = IDLE, enable = 0, result_valid = 0, result_status = 00, result_cycles = 0, captured mask/limit = 0.
REQ-030 Reset mid-RUN SHALL drop enable immediately and discard the run; no result is produced.

Configuration
REQ-031 Macro COUNTERS_RUN_CTRL_TIMEOUT_EN, defined: in RUN with limit != 0 and cycle count + 1 == limit, go to REPORT with status TIMEOUT, so enable was high for exactly limit cycles.
REQ-032 Macro not defined: start_limit SHALL be ignored, TIMEOUT is never reported, and no watchdog logic is instantiated.

Structure
REQ-033 Package counters_run_ctrl_pkg SHALL hold the FSM state enum, the status enum (STAT_OK, STAT_TIMEOUT, STAT_ABORT) and the default widths.
REQ-034 Sub-module counters_run_wdt (saturating cycle counter plus limit compare) SHALL be instantiated only under the macro; without it, the saturating counter is kept inline.

Verification
REQ-035 mask=4'b0011, done bus rises to 4'b0011 on the 5th enable cycle -> enable high 5 cycles, status OK, cycles 5.
REQ-036 Macro defined, mask=4'b1000, limit=10, done never set -> enable high 10 cycles, status TIMEOUT, cycles 10.
REQ-037 Abort on the 3rd RUN cycle -> status ABORT, cycles 3; done matching in the same cycle as abort instead -> status OK.
REQ-038 mask=0 -> no enable pulse, result_valid the next cycle, status OK, cycles 0; start_valid held during REPORT is not accepted.
REQ-039 result_ready held low 4 cycles -> result_valid, status and cycles stable throughout; IDLE on the next cycle after ready.
REQ-040 rst asserted mid-RUN, not aligned to a clk edge -> enable=0 and result_valid=0 immediately; start_ready=1 after release.

Source files
------------

// File: rtl/counters_run_ctrl_pkg.sv
// counters_run_ctrl_pkg: FSM/status encodings and default widths for the counters run controller.
package counters_run_ctrl_pkg;
  localparam int DEF_DONE_W = 4;
  localparam int DEF_CNT_W  = 16;
  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_e;
  typedef enum logic [1:0] {STAT_OK = 2'b00, STAT_TIMEOUT = 2'b01, STAT_ABORT = 2'b10} status_e;
endpackage

// File: rtl/counters_run_wdt.sv
// counters_run_wdt: saturating run-cycle counter with a captured limit compare (0 = no limit).
module counters_run_wdt
  import counters_run_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_timeout
);
  logic [CNT_W-1:0] r_cnt, r_limit, w_inc;
  assign w_inc = r_cnt + CNT_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt   <= '0;
      r_limit <= '0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_limit <= i_limit;
    end else if (i_run && r_cnt != '1) r_cnt <= w_inc;
  assign o_cnt = r_cnt;
  // once saturated w_inc wraps to 0, which a non-zero limit never matches
  assign o_timeout = i_run && (r_limit != '0) && (w_inc == r_limit);
endmodule

// File: rtl/counters_run_ctrl.sv
// counters_run_ctrl: IDLE/RUN/REPORT sequencer gating the counters datapath enable and reporting a result.
// Optional watchdog timeout enabled by defining COUNTERS_RUN_CTRL_TIMEOUT_EN.
module counters_run_ctrl
  import counters_run_ctrl_pkg::*;
#(
  parameter int DONE_W = DEF_DONE_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DONE_W-1:0] start_mask,
  input  logic [CNT_W-1:0]  start_limit,
  input  logic              abort,
  output logic              enable,
  input  logic [DONE_W-1:0] done,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [1:0]        result_status,
  output logic [CNT_W-1:0]  result_cycles
);
  state_e            r_state, w_next;
  status_e           r_status, w_status;
  logic [DONE_W-1:0] r_mask;
  logic [CNT_W-1:0]  w_cnt;
  logic              r_enable, r_valid, w_accept, w_run, w_ok, w_timeout;
  assign start_ready = r_state == IDLE;
  assign w_accept    = start_valid && start_ready;
  assign w_run       = r_state == RUN;
  assign w_ok        = (done & r_mask) == r_mask;
`ifdef COUNTERS_RUN_CTRL_TIMEOUT_EN
  counters_run_wdt #(.CNT_W(CNT_W)) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_accept),
    .i_run    (w_run),
    .i_limit  (start_limit),
    .o_cnt    (w_cnt),
    .o_timeout(w_timeout)
  );
`else
  logic [CNT_W-1:0] r_cnt;
  logic             w_unused_limit;
  assign w_unused_limit = ^start_limit;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (w_accept) r_cnt <= '0;
    else if (w_run && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  assign w_cnt     = r_cnt;
  assign w_timeout = 1'b0;
`endif
  always_comb begin
    w_next   = r_state;
    w_status = r_status;
    case (r_state)
      IDLE:
        if (w_accept) begin
          w_next   = (start_mask == '0) ? REPORT : RUN;
          w_status = STAT_OK;
        end
      RUN:
        if (w_ok || w_timeout || abort) begin
          w_next   = REPORT;
          w_status = w_ok ? STAT_OK : w_timeout ? STAT_TIMEOUT : STAT_ABORT;
        end
      REPORT: w_next = result_ready ? IDLE : REPORT;
      default: w_next = IDLE;
    endcase
  end
  // enable and result_valid are registered copies of the next state so they change with it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= IDLE;
      r_status <= STAT_OK;
      r_mask   <= '0;
      r_enable <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_status <= w_status;
      r_mask   <= w_accept ? start_mask : r_mask;
      r_enable <= w_next == RUN;
      r_valid  <= w_next == REPORT;
    end
  assign enable        = r_enable;
  assign result_valid  = r_valid;
  assign result_status = r_status;
  assign result_cycles = w_cnt;
endmodule

// File: tb/tb_counters_run_ctrl.sv
// tb_counters_run_ctrl: randomized scoreboard bench; driver pushes model results, monitor checks DUT results.
module tb_counters_run_ctrl;
  logic        clk = 0, rst = 1;
  logic        start_valid = 0, start_ready, abort = 0, enable, result_valid, result_ready = 0;
  logic [3:0]  start_mask = 0, done = 0;
  logic [15:0] start_limit = 0, result_cycles;
  logic [1:0]  result_status;
  int vectors = 0, errs = 0;
  typedef struct {int st; int cyc;} exp_t;
  exp_t q[$];
  counters_run_ctrl #(.DONE_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .start_mask(start_mask), .start_limit(start_limit), .abort(abort), .enable(enable),
    .done(done), .result_valid(result_valid), .result_ready(result_ready),
    .result_status(result_status), .result_cycles(result_cycles)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // reference: earliest terminating event wins, ties resolved OK > TIMEOUT > ABORT
  function automatic exp_t model(input logic [3:0] m, input int lim, input int d, input int a);
    exp_t r;
    int best = 1 << 30;
    r.st = 0;
    if (m == 0) begin r.cyc = 0; return r; end
    if (d != 0) begin best = d; r.st = 0; end
`ifdef COUNTERS_RUN_CTRL_TIMEOUT_EN
    if (lim != 0 && lim < best) begin best = lim; r.st = 1; end
`endif
    if (a != 0 && a < best) begin best = a; r.st = 2; end
    r.cyc = best;
    return r;
  endfunction
  // d/a: RUN cycle (1-based) where done matches / abort pulses, 0 = never
  task automatic do_run(input logic [3:0] m, input int lim, input int d, input int a,
                        input int dly, input bit hold);
    int k = 0, w = 0, t = 0;
    while (!start_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (t == 50) chk("idle_wait", 0, 1);
    q.push_back(model(m, lim, d, a));
    start_valid = 1; start_mask = m; start_limit = 16'(lim);
    @(posedge clk); #1;
    start_valid = hold; start_mask = 4'($urandom); start_limit = 16'($urandom);
    for (t = 0; t < 200; t++) begin
      abort = 0; result_ready = 0; done = 4'($urandom);
      if (enable) begin
        k++;
        done = (d != 0 && k >= d) ? (m | 4'($urandom)) : (4'($urandom) & ~m);
        abort = (a != 0 && k == a);
      end
      if (result_valid) begin
        abort = 1'($urandom);
        if (w < dly) w++;
        else begin result_ready = 1; start_valid = 0; end
      end
      @(posedge clk); #1;
      if (result_ready) break;
    end
    if (t == 200) chk("run_timeout", 0, 1);
    result_ready = 0; abort = 0; start_valid = 0;
  endtask
  int lat = -1, en_cnt = 0;
  bit have = 0, hs = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (rst) begin
      lat = -1; en_cnt = 0; have = 0; hs = 0;
    end else begin
      if (hs) begin
        chk("valid_drop", result_valid, 0);
        chk("idle_after", start_ready, 1);
        hs = 0;
      end
      if (lat >= 0) lat++;
      if (enable) en_cnt++;
      if (result_valid) begin
        if (!have) begin
          if (q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            cur = q.pop_front();
            chk("enable_cycles", en_cnt, cur.cyc);
            chk("latency", lat, cur.cyc + 1);
          end
          have = 1;
        end
        chk("status", result_status, cur.st);
        chk("cycles", result_cycles, cur.cyc);
        if (result_ready) begin have = 0; hs = 1; en_cnt = 0; lat = -1; end
      end
      if (start_valid && start_ready) begin lat = 0; en_cnt = 0; end
    end
  end
  initial begin
    int m, d, a, lim;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enable", enable, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_status", result_status, 0);
    chk("rst_cycles", result_cycles, 0);
    chk("rst_ready", start_ready, 1);
    rst = 0;
    @(posedge clk); #1;
    do_run(4'b0011, 0, 5, 0, 0, 0);
`ifdef COUNTERS_RUN_CTRL_TIMEOUT_EN
    do_run(4'b1000, 10, 0, 0, 0, 0);
    do_run(4'b0100, 4, 4, 0, 0, 0);
    do_run(4'b0100, 4, 0, 4, 1, 0);
`endif
    do_run(4'b0001, 0, 0, 3, 0, 1);
    do_run(4'b0001, 0, 3, 3, 0, 0);
    do_run(4'b0000, 0, 0, 0, 2, 1);
    do_run(4'b0110, 7, 2, 0, 4, 1);
    for (int i = 0; i < 40; i++) begin
      m = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 15);
      d = $urandom_range(0, 12);
      a = $urandom_range(0, 12);
      lim = $urandom_range(0, 12);
      if (d == 0 && a == 0) d = $urandom_range(1, 12);
      do_run(4'(m), lim, d, a, $urandom_range(0, 4), 1'($urandom));
    end
    start_valid = 1; start_mask = 4'b1111; start_limit = 0; done = 0;
    @(posedge clk); #1;
    start_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_enable", enable, 1);
    #2 rst = 1;
    #1;
    chk("async_enable", enable, 0);
    chk("async_valid", result_valid, 0);
    @(negedge clk); #2 rst = 0;
    @(posedge clk); #1;
    chk("post_rst_ready", start_ready, 1);
    chk("post_rst_enable", enable, 0);
    do_run(4'b0110, 0, 2, 0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("pending_results", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
